// File: rtl/tz_glyph_fetcher.sv
// Fetches one 32-row glyph from a pipelined block ROM and hands rows to a
// consumer through a small credit-checked row buffer with ready/valid flow.
module tz_glyph_fetcher #(
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        start,
    input  logic [1:0]  glyph_sel,
    output logic        busy,
    output logic        done,
    output logic        rom_ena,
    output logic        rom_regcea,
    output logic [6:0]  rom_addra,
    input  logic [31:0] rom_douta,
    output logic [31:0] row_data,
    output logic [4:0]  row_idx,
    output logic        row_valid,
    input  logic        row_ready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      glyph_reg;
    logic [4:0]      row_cnt_reg;
    logic [6:0]      last_addr_reg;
    logic            pipe_valid_reg [ROM_LATENCY];
    logic [4:0]      pipe_tag_reg   [ROM_LATENCY];
    logic [CW-1:0]   inflight_reg;
    logic [CW-1:0]   fifo_count_reg;
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [31:0]     fifo_data_mem [FIFO_DEPTH];
    logic [4:0]      fifo_idx_mem  [FIFO_DEPTH];

    logic            accept, issue, arrive, pop;
    logic [CW:0]     occupancy;

    // Credits count both reads still in the ROM pipe and rows already buffered,
    // so an arriving row always finds a free slot.
    assign occupancy = {1'b0, inflight_reg} + {1'b0, fifo_count_reg};
    assign arrive    = pipe_valid_reg[ROM_LATENCY-1];
    assign row_valid = (fifo_count_reg != '0);
    assign pop       = row_valid & row_ready;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        issue      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (occupancy < DEPTH_W) begin
                    issue = 1'b1;
                    if (row_cnt_reg == 5'd31) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((inflight_reg == '0) && (fifo_count_reg == '0)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign rom_regcea = (state_reg != IDLE);
    assign rom_ena    = issue;
    assign rom_addra  = (state_reg == IDLE) ? 7'd0 :
                        issue ? {glyph_reg, row_cnt_reg} : last_addr_reg;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            glyph_reg     <= '0;
            row_cnt_reg   <= '0;
            last_addr_reg <= '0;
        end else if (accept) begin
            glyph_reg     <= glyph_sel;
            row_cnt_reg   <= '0;
            last_addr_reg <= {glyph_sel, 5'd0};
        end else if (issue) begin
            row_cnt_reg   <= row_cnt_reg + 5'd1;
            last_addr_reg <= {glyph_reg, row_cnt_reg};
        end
    end

    // Tag pipeline mirrors the ROM latency; the tag is the row number at issue.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_tag_reg[i]   <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= issue;
            pipe_tag_reg[0]   <= row_cnt_reg;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_tag_reg[i]   <= pipe_tag_reg[i-1];
            end
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            inflight_reg <= '0;
        end else begin
            case ({issue, arrive})
                2'b10:   inflight_reg <= inflight_reg + CW'(1);
                2'b01:   inflight_reg <= inflight_reg - CW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (arrive) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({arrive, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (arrive) begin
            fifo_data_mem[wr_ptr_reg] <= rom_douta;
            fifo_idx_mem[wr_ptr_reg]  <= pipe_tag_reg[ROM_LATENCY-1];
        end
    end

    // Head is gated so stale buffer contents never show while empty or in reset.
    assign row_data = row_valid ? fifo_data_mem[rd_ptr_reg] : 32'd0;
    assign row_idx  = row_valid ? fifo_idx_mem[rd_ptr_reg]  : 5'd0;

endmodule

// File: tb/tb_tz_glyph_fetcher.sv
// Bench for tz_glyph_fetcher: behavioural pipelined ROM, negedge monitor,
// table-driven fetches plus hand-written reset/backpressure/restart sequences.
module tb_tz_glyph_fetcher;
    localparam int L = 2;
    localparam int D = 4;

    logic        clk;
    logic        rsta;
    logic        start;
    logic [1:0]  glyph_sel;
    logic        busy, done, rom_ena, rom_regcea, row_valid, row_ready;
    logic [6:0]  rom_addra;
    logic [31:0] rom_douta, row_data;
    logic [4:0]  row_idx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

    logic [6:0]  addr_q[$];
    int          issue_cyc_q[$];
    logic [4:0]  idx_q[$];
    logic [31:0] data_q[$];
    int          done_q[$];

    typedef struct {
        logic [1:0] glyph;
        int         rmode;
        int         restart_at;
        logic [1:0] restart_glyph;
        logic [6:0] exp_first;
        int         exp_lat;
    } vec_t;

    tz_glyph_fetcher #(.ROM_LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clka(clk), .rsta(rsta), .start(start), .glyph_sel(glyph_sel),
        .busy(busy), .done(done), .rom_ena(rom_ena), .rom_regcea(rom_regcea),
        .rom_addra(rom_addra), .rom_douta(rom_douta), .row_data(row_data),
        .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input logic [6:0] a);
        return {8'hC3, 1'b0, a, 1'b1, ~a, 8'(a * 3)};
    endfunction

    logic [6:0] rom_pipe [L];
    always @(posedge clk) begin
        if (rom_ena) rom_pipe[0] <= rom_addra;
        for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_douta = rom_word(rom_pipe[L-1]);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rom_ena) begin
            addr_q.push_back(rom_addra);
            issue_cyc_q.push_back(cyc);
        end
        if (row_valid && row_ready) begin
            idx_q.push_back(row_idx);
            data_q.push_back(row_data);
        end
        if (done) done_q.push_back(cyc);
    end

    function automatic logic [48:0] outs();
        return {busy, done, rom_ena, rom_regcea, rom_addra, row_valid, row_data, row_idx};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (ready_mode == 0)      row_ready = 1'b1;
        else if (ready_mode == 1) row_ready = 1'($urandom_range(0, 1));
        else                      row_ready = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base_d);
        for (int k = 0; k < 2000 && done_q.size() == base_d; k++) step();
        checks++;
        if (done_q.size() == base_d) begin
            failures++;
            $display("FAIL %s_timeout: done not seen within 2000 cycles", name);
        end
    endtask

    task automatic check_fetch(input string name, input int base_a, input int base_r,
                               input int base_d, input logic [6:0] first,
                               input int t_acc, input int exp_lat);
        int n_a, n_r, bad, dl;
        logic [31:0] got;
        n_a = addr_q.size() - base_a;
        bad = -1; got = 0;
        for (int i = 0; i < n_a && i < 32; i++)
            if (bad < 0 && addr_q[base_a+i] != 7'(first + i)) begin
                bad = i; got = 32'(addr_q[base_a+i]);
            end
        checks++;
        if (n_a != 32 || bad >= 0) begin
            failures++;
            $display("FAIL %s_addr: issued=%0d bad_at=%0d got=%0d, required 32 reads from %0d",
                     name, n_a, bad, got, first);
        end
        n_r = idx_q.size() - base_r;
        bad = -1; got = 0;
        for (int i = 0; i < n_r && i < 32; i++)
            if (bad < 0 && (idx_q[base_r+i] != 5'(i) || data_q[base_r+i] != rom_word(7'(first + i)))) begin
                bad = i; got = data_q[base_r+i];
            end
        checks++;
        if (n_r != 32 || bad >= 0) begin
            failures++;
            $display("FAIL %s_rows: rows=%0d bad_at=%0d got_data=%h, required 32 in-order rows (row %0d data %h)",
                     name, n_r, bad, got, bad, (bad >= 0) ? rom_word(7'(first + bad)) : 32'd0);
        end
        checks++;
        if (done_q.size() - base_d != 1) begin
            failures++;
            $display("FAIL %s_done_count: got %0d done pulses, required 1", name, done_q.size() - base_d);
        end
        if (exp_lat >= 0) begin
            dl = (done_q.size() > base_d) ? done_q[base_d] - t_acc : -1;
            checks++;
            if (dl != exp_lat || (n_a == 32 && issue_cyc_q[base_a+31] - issue_cyc_q[base_a] != 31)) begin
                failures++;
                $display("FAIL %s_latency: done after %0d edges, issue span %0d, required %0d and 31",
                         name, dl, (n_a == 32) ? issue_cyc_q[base_a+31] - issue_cyc_q[base_a] : -1, exp_lat);
            end
        end
        checks++;
        if (busy !== 1'b0 || row_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: busy=%b row_valid=%b, required 0 0", name, busy, row_valid);
        end
        $display("TXN %s first_addr=%0d issued=%0d rows=%0d dones=%0d", name, first, n_a, n_r,
                 done_q.size() - base_d);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int ba, br, bd, t_acc;
        bit restarted;
        ready_mode = v.rmode;
        ba = addr_q.size(); br = idx_q.size(); bd = done_q.size();
        glyph_sel = v.glyph;
        start = 1'b1;
        t_acc = cyc + 1;
        step();
        start = 1'b0;
        glyph_sel = ~v.glyph;
        restarted = 0;
        for (int k = 0; k < 2000 && done_q.size() == bd; k++) begin
            if (v.restart_at >= 0 && !restarted && idx_q.size() - br >= v.restart_at) begin
                start = 1'b1;
                glyph_sel = v.restart_glyph;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        checks++;
        if (done_q.size() == bd) begin
            failures++;
            $display("FAIL %s_timeout: done not seen within 2000 cycles", name);
        end
        ready_mode = 0;
        repeat (4) step();
        check_fetch(name, ba, br, bd, v.exp_first, t_acc, v.exp_lat);
    endtask

    initial begin
        vec_t vecs[4];
        vec_t v0;
        int ba, br, bd, t_acc;

        vecs[0] = '{glyph: 2'd1, rmode: 0, restart_at: -1, restart_glyph: 2'd0, exp_first: 7'd32, exp_lat: 35};
        vecs[1] = '{glyph: 2'd3, rmode: 1, restart_at: -1, restart_glyph: 2'd0, exp_first: 7'd96, exp_lat: -1};
        vecs[2] = '{glyph: 2'd1, rmode: 0, restart_at: 10, restart_glyph: 2'd2, exp_first: 7'd32, exp_lat: 35};
        vecs[3] = '{glyph: 2'd2, rmode: 1, restart_at: 5,  restart_glyph: 2'd0, exp_first: 7'd64, exp_lat: -1};
        v0      = '{glyph: 2'd0, rmode: 0, restart_at: -1, restart_glyph: 2'd0, exp_first: 7'd0,  exp_lat: 35};

        rsta = 1'b1; start = 1'b0; glyph_sel = 2'd0; row_ready = 1'b0;
        repeat (3) step();
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0", outs());
        end

        // Start raised together with reset release: accepted on the first edge.
        ba = addr_q.size(); br = idx_q.size(); bd = done_q.size();
        rsta = 1'b0; start = 1'b1; glyph_sel = 2'd2;
        t_acc = cyc + 1;
        step();
        start = 1'b0; glyph_sel = 2'd0;
        checks++;
        if (!(busy === 1'b1 && rom_ena === 1'b1 && rom_addra === 7'd64 && rom_regcea === 1'b1)) begin
            failures++;
            $display("FAIL first_start: busy=%b ena=%b addr=%0d regcea=%b, required 1 1 64 1",
                     busy, rom_ena, rom_addra, rom_regcea);
        end
        wait_done("after_reset", bd);
        repeat (4) step();
        check_fetch("after_reset", ba, br, bd, 7'd64, t_acc, 35);

        for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Consumer stalled: buffer fills, head holds row 0, reads stop.
        ready_mode = 2;
        step();
        ba = addr_q.size(); br = idx_q.size(); bd = done_q.size();
        start = 1'b1; glyph_sel = 2'd1;
        step();
        start = 1'b0;
        repeat (9) step();
        checks++;
        if (addr_q.size() - ba != D) begin
            failures++;
            $display("FAIL bp_issue_count: got %0d reads, required %0d", addr_q.size() - ba, D);
        end
        checks++;
        if (!(row_valid === 1'b1 && row_idx === 5'd0 && row_data === rom_word(7'd32) && rom_ena === 1'b0)) begin
            failures++;
            $display("FAIL bp_head_hold: valid=%b idx=%0d data=%h ena=%b, required 1 0 %h 0",
                     row_valid, row_idx, row_data, rom_ena, rom_word(7'd32));
        end
        ready_mode = 0;
        wait_done("backpressure", bd);
        repeat (4) step();
        check_fetch("backpressure", ba, br, bd, 7'd32, 0, -1);

        // Reset in the middle of a fetch.
        ready_mode = 0;
        ba = addr_q.size(); br = idx_q.size(); bd = done_q.size();
        start = 1'b1; glyph_sel = 2'd3;
        step();
        start = 1'b0;
        for (int k = 0; k < 500 && idx_q.size() - br < 15; k++) step();
        rsta = 1'b1;
        #1;
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL reset_mid_op: got %h, required 0", outs());
        end
        step();
        rsta = 1'b0;
        bd = done_q.size();
        repeat (6) step();
        checks++;
        if (done_q.size() != bd || row_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done: dones=%0d valid=%b busy=%b, required 0 0 0",
                     done_q.size() - bd, row_valid, busy);
        end
        run_vec("after_mid_reset", v0);

        // Start held through the done cycle: ignored there, accepted next cycle.
        bd = done_q.size();
        start = 1'b1; glyph_sel = 2'd1;
        step();
        start = 1'b0;
        for (int k = 0; k < 2000 && done !== 1'b1; k++) step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_wait_timeout: done not seen, required a done pulse");
        end
        start = 1'b1; glyph_sel = 2'd2;
        step();
        ba = addr_q.size(); br = idx_q.size(); bd = done_q.size();
        checks++;
        if (busy !== 1'b0 || rom_ena !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done: busy=%b ena=%b, required 0 0", busy, rom_ena);
        end
        t_acc = cyc + 1;
        step();
        start = 1'b0; glyph_sel = 2'd0;
        checks++;
        if (!(busy === 1'b1 && rom_ena === 1'b1 && rom_addra === 7'd64)) begin
            failures++;
            $display("FAIL start_after_done: busy=%b ena=%b addr=%0d, required 1 1 64",
                     busy, rom_ena, rom_addra);
        end
        wait_done("after_done_restart", bd);
        repeat (4) step();
        check_fetch("after_done_restart", ba, br, bd, 7'd64, t_acc, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
